// File: rtl/leading_zeros_pipe_pkg.sv
// Shared helpers for the leading-zero/one counter: tree depth, register
// placement across tree levels, and the 4-bit leaf priority encoder.
package lz_pkg;

   localparam int DEF_SIZE_COUNTER = 5;
   localparam int MAX_POW_2        = 2**DEF_SIZE_COUNTER;

   function automatic int lz_levels(input int size_counter);
      return size_counter - 1;
   endfunction

   // Slot i in 0..nr_levels (nr_levels = the output stage) gets a register when
   // the evenly spread boundary count steps up there; the output slot always does.
   function automatic bit stage_after_level(input int i, input int pipeline,
                                            input int nr_levels);
      return ((i + 1) * pipeline) / (nr_levels + 1) != (i * pipeline) / (nr_levels + 1);
   endfunction

   function automatic logic [1:0] leaf_pos(input logic [3:0] x);
      if (x[3])      return 2'd0;
      else if (x[2]) return 2'd1;
      else if (x[1]) return 2'd2;
      else           return 2'd3;
   endfunction

endpackage

// File: rtl/leading_zeros_pipe_if.sv
// Handshaked operand/result channel of the leading-zero counter.
interface leading_zeros_pipe_if #(
   parameter int SIZE_INT     = 24,
   parameter int SIZE_COUNTER = 5,
   parameter int TAG_W        = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [SIZE_INT-1:0]     a;
   logic                    ovf;
   logic                    cnt_ones;
   logic [TAG_W-1:0]        in_tag;
   logic                    out_valid;
   logic                    out_ready;
   logic [SIZE_COUNTER-1:0] lz;
   logic                    all_zero;
   logic [TAG_W-1:0]        out_tag;

   modport master (
      output in_valid, a, ovf, cnt_ones, in_tag, out_ready,
      input  in_ready, out_valid, lz, all_zero, out_tag
   );

   modport slave (
      input  in_valid, a, ovf, cnt_ones, in_tag, out_ready,
      output in_ready, out_valid, lz, all_zero, out_tag
   );
endinterface

// File: rtl/leading_zeros_pipe_stage_reg.sv
// Enable-gated register bank with asynchronous active-low clear; one per
// pipeline boundary of the leading-zero tree.
module lz_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] data_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    data_q <= '0;
      else if (en) data_q <= d;
   end

   assign q = data_q;
endmodule

// File: rtl/leading_zeros_pipe.sv
// Leading-zero / leading-one counter built as a 4-bit-leaf priority tree with
// optional registers between levels under a global valid/ready stall.
module leading_zeros_pipe
   import lz_pkg::*;
#(
   parameter int SIZE_INT     = 24,
   parameter int SIZE_COUNTER = 5,
   parameter int PIPELINE     = 2,
   parameter int TAG_W        = 8
) (
   input logic                clk,
   input logic                rst,
   leading_zeros_pipe_if.slave bus
);
   localparam int NR_LEVELS = lz_levels(SIZE_COUNTER);
   localparam int MAXP      = 1 << SIZE_COUNTER;
   localparam int PAD       = MAXP - SIZE_INT;
   localparam int LAST      = NR_LEVELS - 1;

   function automatic logic [SIZE_COUNTER-1:0] sat_count(input logic v,
         input logic [SIZE_COUNTER-1:0] p, input logic ovf_f);
      if (ovf_f) return '0;
      if (!v)    return SIZE_COUNTER'(SIZE_INT);
      return p;
   endfunction

   logic                adv;
   logic [SIZE_INT-1:0] b;
   logic [MAXP-1:0]     b_pad;

   assign b     = bus.cnt_ones ? ~bus.a : bus.a;
   assign b_pad = {b, {PAD{1'b0}}};

   // Group index 0 is the most significant group at every level.
   for (genvar l = 0; l < NR_LEVELS; l++) begin : lvl
      localparam int G  = MAXP >> (l + 2);
      localparam int PW = l + 2;
      localparam int W  = G + G * PW + 2 + TAG_W;

      logic [G-1:0]          v_d, v_q;
      logic [G-1:0][PW-1:0]  p_d, p_q;
      logic                  ovf_d, ovf_q, vld_d, vld_q;
      logic [TAG_W-1:0]      tag_d, tag_q;

      if (l == 0) begin : leaf
         for (genvar g = 0; g < G; g++) begin : grp
            assign v_d[g] = |b_pad[MAXP-1-4*g -: 4];
            assign p_d[g] = leaf_pos(b_pad[MAXP-1-4*g -: 4]);
         end
         assign ovf_d = bus.ovf;
         assign vld_d = bus.in_valid;
         assign tag_d = bus.in_tag;
      end else begin : merge
         for (genvar g = 0; g < G; g++) begin : grp
            logic vh, vl;
            assign vh     = lvl[l-1].v_q[2*g];
            assign vl     = lvl[l-1].v_q[2*g+1];
            assign v_d[g] = vh | vl;
            assign p_d[g] = vh ? {1'b0, lvl[l-1].p_q[2*g]} : {1'b1, lvl[l-1].p_q[2*g+1]};
         end
         assign ovf_d = lvl[l-1].ovf_q;
         assign vld_d = lvl[l-1].vld_q;
         assign tag_d = lvl[l-1].tag_q;
      end

      if (stage_after_level(l, PIPELINE, NR_LEVELS)) begin : reg_g
         lz_stage_reg #(.W(W)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (adv),
            .d   ({v_d, p_d, ovf_d, vld_d, tag_d}),
            .q   ({v_q, p_q, ovf_q, vld_q, tag_q})
         );
      end else begin : thru_g
         assign {v_q, p_q, ovf_q, vld_q, tag_q} = {v_d, p_d, ovf_d, vld_d, tag_d};
      end
   end

   logic [SIZE_COUNTER-1:0] lz_d, lz_q;
   logic                    zero_d, zero_q, vld_d, vld_q;
   logic [TAG_W-1:0]        tag_d, tag_q;

   // The root valid bit is the "any bit set" flag, padding LSBs being zero.
   assign lz_d   = sat_count(lvl[LAST].v_q[0], lvl[LAST].p_q[0], lvl[LAST].ovf_q);
   assign zero_d = ~lvl[LAST].v_q[0];
   assign vld_d  = lvl[LAST].vld_q;
   assign tag_d  = lvl[LAST].tag_q;

   if (stage_after_level(NR_LEVELS, PIPELINE, NR_LEVELS)) begin : out_reg_g
      lz_stage_reg #(.W(SIZE_COUNTER + 2 + TAG_W)) u_reg (
         .clk (clk),
         .rst (rst),
         .en  (adv),
         .d   ({lz_d, zero_d, vld_d, tag_d}),
         .q   ({lz_q, zero_q, vld_q, tag_q})
      );
   end else begin : out_thru_g
      assign {lz_q, zero_q, vld_q, tag_q} = {lz_d, zero_d, vld_d, tag_d};
   end

   if (PIPELINE > 0) begin : flow_pipe
      logic stall;
      assign stall        = vld_q & ~bus.out_ready;
      assign adv          = ~stall;
      assign bus.in_ready = ~stall;
   end else begin : flow_comb
      assign adv          = 1'b1;
      assign bus.in_ready = bus.out_ready;
   end

   assign bus.out_valid = vld_q;
   assign bus.lz        = lz_q;
   assign bus.all_zero  = zero_q;
   assign bus.out_tag   = tag_q;
endmodule

// File: doc/leading_zeros_pipe.md
Name: leading_zeros_pipe

Overview:
- Parametrised, fully handshaked successor to the combinational/fixed-pipeline leading-zero counter used in the dual-path FP adder normalisation path.
- Counts leading zeros, or leading ones (runtime select), of a SIZE_INT-bit mantissa using a 4-bit-leaf priority tree.
- Adds an explicit all-zero flag and an ovf override.
- Register stages carry valid/ready flow control and a sideband tag, so the block can sit between stall-capable adder pipeline stages.

Parameters:
- SIZE_INT, 24, mantissa width in bits; 4 <= SIZE_INT < 2**SIZE_COUNTER.
- SIZE_COUNTER, 5, width of the lz result; tree depth nr_levels = SIZE_COUNTER-1.
- PIPELINE, 2, number of register stages, 0..SIZE_COUNTER; 0 = purely combinational.
- TAG_W, 8, width of the sideband tag carried alongside the data; minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- in_valid  input  1  a, ovf, cnt_ones and in_tag are valid.
- in_ready  output  1  block accepts input this cycle.
- a  input  SIZE_INT  operand, MSB-first.
- ovf  input  1  adder overflow; forces lz to 0.
- cnt_ones  input  1  0 = count leading zeros; 1 = count leading ones.
- in_tag  input  TAG_W  opaque sideband data.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- lz  output  SIZE_COUNTER  leading count.
- all_zero  output  1  operand (after optional inversion) had no set bit.
- out_tag  output  TAG_W  in_tag delayed with its result.

Behaviour:
- Reset: rst low clears all stage valid bits and all data/tag registers to 0 immediately, regardless of clk.
  - While reset is asserted: out_valid=0, lz=0, all_zero=0, out_tag=0.
  - An in-flight transfer is discarded.
  - in_ready=1 from the first cycle after rst deasserts.
- Operand formation:
  - b = cnt_ones ? ~a : a.
  - b is left-aligned into a 2**SIZE_COUNTER vector; the padding LSBs are zero.
- Count:
  - lz = index distance from the MSB of b to its first 1.
  - If b == 0: lz = SIZE_INT (saturated, not the raw tree value) and all_zero = 1.
  - If ovf == 1: lz = 0, whatever b is. all_zero still reflects b.
- Tree:
  - Level 0: 4-bit leaf groups, each producing a valid bit and a 2-bit position.
  - Each higher level merges pairs and adds one position bit.
  - The final level yields SIZE_COUNTER bits.
- Pipeline:
  - PIPELINE register stages hold tree state (v, p), ovf, the zero flag and the tag.
  - Boundaries are spaced as evenly as possible across the nr_levels tree levels plus the output.
  - Latency is exactly PIPELINE cycles from input handshake to out_valid.
- Flow control (PIPELINE > 0): global stall model.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - All stages advance together when ~stall.
  - Bubbles (valid=0) advance normally; no bubble collapsing is required.
  - Throughput is 1 result per cycle when out_ready is held high.
- Flow control (PIPELINE = 0): out_valid = in_valid, in_ready = out_ready, and outputs are combinational from the inputs.
- Stability: while out_valid=1 and out_ready=0, lz, all_zero and out_tag hold constant.
- No transfer is lost or duplicated.
- in_ready may depend combinationally on out_ready.
- in_valid is accepted only when in_ready=1. Input changes while in_ready=0 are ignored.

Decomposition:
- Package lz_pkg:
  - constant function lz_levels(SIZE_COUNTER);
  - function stage_after_level(i, PIPELINE, nr_levels) returning register placement;
  - localparam MAX_POW_2 = 2**SIZE_COUNTER.
- Sub-module lz_stage_reg #(W):
  - enable-gated register bank with asynchronous active-low clear;
  - ports clk, rst, en, d, q;
  - instantiated once per pipeline boundary for v/p/ovf/zero/tag/valid.
- Tree levels are generated inline.

Test Plan:
- SIZE_INT=24, PIPELINE=2, cnt_ones=0, a=0x000100, ovf=0 -> after 2 cycles out_valid=1, lz=15, all_zero=0, out_tag equals the in_tag applied.
- a=0x800000 -> lz=0. a=0x000000 -> lz=24, all_zero=1. a=0x000001 with ovf=1 -> lz=0, all_zero=0.
- cnt_ones=1, a=0xFFF0FF -> lz=12. cnt_ones=1, a=0xFFFFFF -> lz=24, all_zero=1.
- Back-to-back: 16 random operands with tags, out_ready=1 -> 16 results in consecutive cycles, in order, each matching the reference model.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> outputs stable and in_ready=0. The held inputs are accepted once out_ready=1, with no loss or duplicates.
- Reset mid-stream: assert rst low asynchronously with 2 results in flight -> out_valid=0 and lz=0 immediately. After release the first new operand appears 2 cycles after acceptance.
- Repeat the count checks with PIPELINE=0 (combinational, same values) and PIPELINE=SIZE_COUNTER (latency 5).
